xfft_frame_sequencer: RTL and testbench

//  Sequences the AXI-stream FFT core: issues one config word per frame, forwards input samples with generated tlast

---
 rtl/xfft_frame_sequencer.sv | 178 +++++++++++++++++
 tb/tb_xfft_frame_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/xfft_frame_sequencer.sv
// Frame sequencer for an AXI-stream FFT core: one config word per frame, tlast generation, result frame counting.
// Optional result framing check is compiled in when XFFT_SEQ_LAST_CHECK_EN is defined.
module xfft_frame_sequencer #(
  parameter int unsigned P_SAMPLE_NUM     = 1,
  parameter int unsigned P_FIXED_WID      = 16,
  parameter int unsigned P_FFT_NUM_SAMPLE = 256,
  parameter int unsigned P_CONFIG_WID     = 16,
  parameter int unsigned P_WID            = 2 * P_SAMPLE_NUM * P_FIXED_WID,
  parameter int unsigned P_BEATS          = P_FFT_NUM_SAMPLE / P_SAMPLE_NUM
) (
  input  logic                    axis_clk,
  input  logic                    axis_reset_n,
  input  logic                    ctl_start,
  input  logic                    ctl_stop,
  input  logic [15:0]             ctl_frames,
  input  logic                    ctl_inverse,
  input  logic [P_CONFIG_WID-2:0] ctl_scale,
  output logic                    sts_busy,
  output logic                    sts_done,
  output logic [15:0]             sts_frame_cnt,
  output logic                    sts_err,
  output logic [7:0]              sts_err_cnt,
  output logic                    m_cfg_tvalid,
  input  logic                    m_cfg_tready,
  output logic [P_CONFIG_WID-1:0] m_cfg_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [P_WID-1:0]        s_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [P_WID-1:0]        m_axis_tdata,
  output logic                    m_axis_tlast,
  input  logic                    res_tvalid,
  input  logic                    res_tready,
  input  logic                    res_tlast
);

  localparam int unsigned BEAT_W = (P_BEATS > 1) ? $clog2(P_BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(P_BEATS - 1);

  typedef enum logic [2:0] {IDLE, CFG, DATA, DRAIN, DONE} state_t;

  state_t                  state;
  logic [15:0]             frames;
  logic [15:0]             issued;
  logic [15:0]             done_cnt;
  logic                    stop_pend;
  logic [BEAT_W-1:0]       beat_cnt;
  logic                    busy;
  logic                    done;
  logic                    cfg_valid;
  logic [P_CONFIG_WID-1:0] cfg_word;

  logic        in_data;
  logic        beat_hs;
  logic        res_frame;
  logic        start_acc;
  logic [15:0] issued_nxt;

  // Zero-latency sample path, gated to the DATA phase
  assign in_data       = (state == DATA);
  assign m_axis_tvalid = in_data & s_axis_tvalid;
  assign s_axis_tready = in_data & m_axis_tready;
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tlast  = in_data & (beat_cnt == LAST_BEAT);

  assign beat_hs    = m_axis_tvalid & m_axis_tready;
  assign res_frame  = res_tvalid & res_tready & res_tlast;
  assign start_acc  = (state == IDLE) & ctl_start;
  assign issued_nxt = issued + 16'd1;

  assign sts_busy      = busy;
  assign sts_done      = done;
  assign sts_frame_cnt = done_cnt;
  assign m_cfg_tvalid  = cfg_valid;
  assign m_cfg_tdata   = cfg_word;

  always_ff @(posedge axis_clk) begin
    if (!axis_reset_n) begin
      state     <= IDLE;
      frames    <= '0;
      issued    <= '0;
      done_cnt  <= '0;
      stop_pend <= 1'b0;
      beat_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_valid <= 1'b0;
      cfg_word  <= '0;
    end else begin
      // Result monitor runs in every state; a start clears it below
      if (res_frame) done_cnt <= done_cnt + 16'd1;
      case (state)
        IDLE: begin
          if (start_acc) begin
            frames    <= ctl_frames;
            cfg_word  <= {ctl_scale, ~ctl_inverse};
            issued    <= '0;
            done_cnt  <= '0;
            stop_pend <= 1'b0;
            beat_cnt  <= '0;
            busy      <= 1'b1;
            cfg_valid <= 1'b1;
            state     <= CFG;
          end
        end
        CFG: begin
          if (ctl_stop) stop_pend <= 1'b1;
          if (cfg_valid && m_cfg_tready) begin
            cfg_valid <= 1'b0;
            state     <= DATA;
          end
        end
        DATA: begin
          if (ctl_stop) stop_pend <= 1'b1;
          if (beat_hs) begin
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= '0;
              issued   <= issued_nxt;
              if ((frames != 16'd0 && issued_nxt == frames) || stop_pend || ctl_stop) begin
                state <= DRAIN;
              end else begin
                cfg_valid <= 1'b1;
                state     <= CFG;
              end
            end else begin
              beat_cnt <= beat_cnt + BEAT_W'(1);
            end
          end
        end
        DRAIN: begin
          if (done_cnt == issued) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef XFFT_SEQ_LAST_CHECK_EN
  logic [BEAT_W-1:0] res_cnt;
  logic              err_q;
  logic [7:0]        err_cnt_q;
  logic              res_hs;
  logic              res_bad;

  // A beat is misframed when tlast disagrees with the expected last position
  assign res_hs  = res_tvalid & res_tready;
  assign res_bad = res_hs & (res_tlast != (res_cnt == LAST_BEAT));

  always_ff @(posedge axis_clk) begin
    if (!axis_reset_n) begin
      res_cnt   <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_q <= res_bad;
      if (res_hs) res_cnt <= (res_tlast || res_cnt == LAST_BEAT) ? '0 : res_cnt + BEAT_W'(1);
      if (start_acc) err_cnt_q <= '0;
      else if (res_bad && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign sts_err     = err_q;
  assign sts_err_cnt = err_cnt_q;
`else
  assign sts_err     = 1'b0;
  assign sts_err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_xfft_frame_sequencer.sv
// Self-checking bench for xfft_frame_sequencer (8-sample frames): table of sequence runs with random
// handshakes against a beat/frame-level reference, plus hand-written stall, reset and framing-error cases.
module tb_xfft_frame_sequencer;

  localparam int unsigned NS    = 8;
  localparam int unsigned WID   = 32;
  localparam int unsigned LIMIT = 3000;

  logic             axis_clk = 1'b0;
  logic             axis_reset_n = 1'b0;
  logic             ctl_start = 1'b0, ctl_stop = 1'b0, ctl_inverse = 1'b0;
  logic [15:0]      ctl_frames = '0;
  logic [14:0]      ctl_scale = '0;
  logic             sts_busy, sts_done, sts_err;
  logic [15:0]      sts_frame_cnt;
  logic [7:0]       sts_err_cnt;
  logic             m_cfg_tvalid, m_cfg_tready = 1'b0;
  logic [15:0]      m_cfg_tdata;
  logic             s_axis_tvalid = 1'b0, s_axis_tready;
  logic [WID-1:0]   s_axis_tdata = '0;
  logic             m_axis_tvalid, m_axis_tready = 1'b0, m_axis_tlast;
  logic [WID-1:0]   m_axis_tdata;
  logic             res_tvalid = 1'b0, res_tready = 1'b0, res_tlast = 1'b0;

  xfft_frame_sequencer #(.P_FFT_NUM_SAMPLE(NS)) dut (
    .axis_clk(axis_clk), .axis_reset_n(axis_reset_n),
    .ctl_start(ctl_start), .ctl_stop(ctl_stop), .ctl_frames(ctl_frames),
    .ctl_inverse(ctl_inverse), .ctl_scale(ctl_scale),
    .sts_busy(sts_busy), .sts_done(sts_done), .sts_frame_cnt(sts_frame_cnt),
    .sts_err(sts_err), .sts_err_cnt(sts_err_cnt),
    .m_cfg_tvalid(m_cfg_tvalid), .m_cfg_tready(m_cfg_tready), .m_cfg_tdata(m_cfg_tdata),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast),
    .res_tvalid(res_tvalid), .res_tready(res_tready), .res_tlast(res_tlast)
  );

  always #5 axis_clk = ~axis_clk;

  int n_vec = 0, n_err = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, want, $time);
    end
  endtask

  // Reference view of the stream: a frame opens on an accepted config word and lasts NS accepted beats
  bit          mon_en = 0;
  bit          in_data = 0;
  int          beats_left = 0;
  int          cfg_seen = 0, last_seen = 0, beats_seen = 0, done_seen = 0, err_seen = 0;
  logic [15:0] exp_cfg = '0;
  bit          cfg_hold = 0;
  logic [15:0] held_cfg = '0;
  logic [4:0]  act_v, exp_v;

  always @(negedge axis_clk) begin
    if (mon_en) begin
      exp_v = {in_data & s_axis_tvalid, in_data & m_axis_tready,
               in_data & s_axis_tvalid & (beats_left == 1), 1'b0, 1'b0};
      act_v = {m_axis_tvalid, s_axis_tready, m_axis_tvalid & m_axis_tlast,
               m_axis_tvalid & (m_axis_tdata != s_axis_tdata), m_cfg_tvalid & in_data};
      check("datapath", 64'(act_v), 64'(exp_v));
      if (cfg_hold) check("cfg_hold", {47'd0, m_cfg_tvalid, m_cfg_tdata}, {47'd0, 1'b1, held_cfg});
      cfg_hold = m_cfg_tvalid & ~m_cfg_tready;
      held_cfg = m_cfg_tdata;
      if (m_cfg_tvalid && m_cfg_tready) begin
        check("cfg_word", 64'(m_cfg_tdata), 64'(exp_cfg));
        cfg_seen++;
        in_data = 1;
        beats_left = NS;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        beats_seen++;
        if (beats_left > 0) beats_left--;
        if (beats_left == 0) begin
          in_data = 0;
          last_seen++;
        end
      end
      if (sts_done) done_seen++;
      if (sts_err) err_seen++;
      if (!axis_reset_n) begin
        in_data = 0;
        beats_left = 0;
        cfg_hold = 0;
      end
    end
  end

  typedef struct {
    logic [15:0] frames;
    logic        inv;
    logic [14:0] scale;
    int          stop_frame;  // 1-based frame during which ctl_stop is pulsed, 0 = none
    int          stall;       // cycles m_cfg_tready is held low after start
    bit          restart;     // pulse start (with frames=7) while busy
    bit          rnd;         // randomise handshakes
    logic [15:0] cfg;         // expected config word
    int          nfr;         // expected frames run
  } vec_t;

  vec_t vecs[6];

  task automatic run_seq(input vec_t v);
    int  cyc = 0, res_sent = 0, busy_low = 0, done0;
    bit  stopped = 0, restarted = 0;
    exp_cfg = v.cfg;
    cfg_seen = 0; last_seen = 0; beats_seen = 0;
    ctl_frames = v.frames; ctl_inverse = v.inv; ctl_scale = v.scale; ctl_start = 1;
    @(posedge axis_clk); #1;
    done0 = done_seen;
    while (done_seen == done0 && cyc < LIMIT) begin
      ctl_start = 0; ctl_stop = 0;
      m_cfg_tready  = (cyc < v.stall) ? 1'b0 : (v.rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      s_axis_tvalid = v.rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      m_axis_tready = v.rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_axis_tdata  = $urandom;
      if (v.stop_frame != 0 && !stopped && last_seen == v.stop_frame - 1 && beats_left == 5) begin
        ctl_stop = 1; stopped = 1;
      end
      if (v.restart && !restarted && last_seen == 0 && beats_left == 4) begin
        ctl_start = 1; ctl_frames = 16'd7; restarted = 1;
      end
      res_tvalid = 0; res_tlast = 0;
      res_tready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (res_sent < last_seen * NS && (!v.rnd || $urandom_range(0, 1) == 1)) begin
        res_tvalid = 1;
        res_tlast  = (res_sent % NS) == NS - 1;
      end
      @(negedge axis_clk);
      if (cyc < v.stall)
        check("cfg_stall", {47'd0, m_cfg_tvalid, m_cfg_tdata, s_axis_tready},
              {47'd0, 1'b1, v.cfg, 1'b0});
      if (res_tvalid && res_tready) res_sent++;
      if (!sts_busy) busy_low++;
      @(posedge axis_clk); #1;
      cyc++;
    end
    ctl_start = 0; ctl_stop = 0; res_tvalid = 0; res_tlast = 0;
    check("timeout", 64'(cyc < LIMIT), 64'd1);
    check("cfg_count", 64'(cfg_seen), 64'(v.nfr));
    check("frames_in", 64'(last_seen), 64'(v.nfr));
    check("beats_in", 64'(beats_seen), 64'(v.nfr * NS));
    check("busy_gap", 64'(busy_low), 64'd0);
    @(negedge axis_clk);
    check("frame_cnt", 64'(sts_frame_cnt), 64'(v.nfr));
    check("done_pulses", 64'(done_seen - done0), 64'd1);
    check("idle_after", {62'd0, sts_busy, sts_done}, 64'd0);
    @(posedge axis_clk); #1;
  endtask

  task automatic res_beat(input logic last, input logic want_err);
    res_tvalid = 1; res_tready = 1; res_tlast = last;
    @(posedge axis_clk); #1;
    res_tvalid = 0; res_tlast = 0;
    @(negedge axis_clk);
    check("err_pulse", 64'(sts_err), 64'(want_err));
    @(posedge axis_clk); #1;
  endtask

  initial begin
    int wcyc;
    vecs[0] = '{16'd0 + 2, 1'b0, 15'h0000, 0, 0, 1'b0, 1'b0, 16'h0001, 2};
    vecs[1] = '{16'd0,     1'b0, 15'h1234, 2, 0, 1'b0, 1'b1, 16'h2469, 2};
    vecs[2] = '{16'd0 + 3, 1'b1, 15'h7FFF, 0, 0, 1'b1, 1'b1, 16'hFFFE, 3};
    vecs[3] = '{16'd0 + 1, 1'b1, 15'h2AAA, 0, 5, 1'b0, 1'b1, 16'h5554, 1};
    vecs[4] = '{16'd0 + 4, 1'b0, 15'h2AAA, 2, 0, 1'b0, 1'b1, 16'h5555, 2};
    vecs[5] = '{16'd0,     1'b1, 15'h0000, 1, 0, 1'b0, 1'b1, 16'h0000, 1};

    // Reset state, with inputs that would otherwise open the datapath
    s_axis_tvalid = 1; m_axis_tready = 1;
    repeat (3) @(posedge axis_clk);
    #1;
    @(negedge axis_clk);
    check("reset_outs", {53'd0, sts_busy, sts_done, sts_err, m_cfg_tvalid, s_axis_tready, m_axis_tvalid,
                         m_axis_tlast, 4'd0}, 64'd0);
    check("reset_cnts", {40'd0, sts_frame_cnt, sts_err_cnt}, 64'd0);
    @(posedge axis_clk); #1;
    axis_reset_n = 1; s_axis_tvalid = 0; m_axis_tready = 0;
    mon_en = 1;
    @(posedge axis_clk); #1;

    for (int i = 0; i < 6; i++) run_seq(vecs[i]);

    // Reset mid-frame abandons the frame; the next run must count beats from zero
    exp_cfg = 16'h0001;
    ctl_frames = 16'd2; ctl_inverse = 0; ctl_scale = '0; ctl_start = 1;
    m_cfg_tready = 1; s_axis_tvalid = 1; m_axis_tready = 1;
    @(posedge axis_clk); #1;
    ctl_start = 0;
    wcyc = 0;
    while (beats_left != 5 && wcyc < 50) begin
      s_axis_tdata = $urandom;
      @(posedge axis_clk); #1;
      wcyc++;
    end
    check("mid_frame_reached", 64'(beats_left), 64'd5);
    axis_reset_n = 0; s_axis_tvalid = 0;
    @(posedge axis_clk); #1;
    axis_reset_n = 1; s_axis_tvalid = 1;
    @(negedge axis_clk);
    check("rst_mid_outs", {58'd0, sts_busy, sts_done, m_cfg_tvalid, s_axis_tready, m_axis_tvalid, m_axis_tlast},
          64'd0);
    check("rst_mid_cnt", 64'(sts_frame_cnt), 64'd0);
    @(posedge axis_clk); #1;
    s_axis_tvalid = 0;
    run_seq(vecs[0]);

`ifdef XFFT_SEQ_LAST_CHECK_EN
    for (int i = 0; i < 5; i++) res_beat(i == 4, i == 4);
    check("err_cnt_early", 64'(sts_err_cnt), 64'd1);
    for (int i = 0; i < 8; i++) res_beat(i == 7, 1'b0);
    check("err_cnt_good", 64'(sts_err_cnt), 64'd1);
    for (int i = 0; i < 8; i++) res_beat(1'b0, i == 7);
    check("err_cnt_missing", 64'(sts_err_cnt), 64'd2);
    run_seq(vecs[3]);
    check("err_cnt_cleared", 64'(sts_err_cnt), 64'd0);
`else
    check("err_tied", {55'd0, sts_err, sts_err_cnt}, 64'd0);
    check("err_pulses", 64'(err_seen), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
